// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: FSM encodings, requester IDs and counter helper shared by the data-memory arbiter
package dmem_arbiter_pkg;
    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;
    localparam logic ID_R0 = 1'b0;
    localparam logic ID_R1 = 1'b1;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;
    function automatic logic [15:0] sat_inc(input logic [15:0] c, input logic en);
        return (en && c != CNT_MAX) ? c + 16'd1 : c;
    endfunction
endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin picker; the requester that did not win last goes first
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       win_id,
    output logic       any
);
    // lone requester wins outright; on a tie the one that is not last wins
    always_comb begin
        any    = |req;
        win_id = &req ? ~last : req[1];
    end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sequencer sharing the data memory port between r0 and r1; DMEM_ARB_PERF_EN adds grant/conflict counters
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r0_gnt,
    output logic              r1_gnt,
    output logic              r0_rvalid,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    output logic [DATA_W-1:0] r1_rdata,
    output logic [ADDR_W-1:0] mem_access_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_en,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_read_data
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [15:0]       r0_gnt_cnt,
    output logic [15:0]       r1_gnt_cnt,
    output logic [15:0]       conflict_cnt
`endif
);
    state_t            state;
    logic              last, we_q, id_q, win, any;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [1:0]        gnt;

    rr_arb2 u_arb (
        .req   ({r1_req, r0_req}),
        .last  (last),
        .win_id(win),
        .any   (any)
    );

    assign r0_gnt          = gnt[0];
    assign r1_gnt          = gnt[1];
    assign mem_access_addr = addr_q;
    assign mem_write_data  = wdata_q;

    // grant in IDLE; memory strobes only during ACCESS and never at a reset edge
    always_comb begin
        gnt          = (state == IDLE && any && !rst) ? (win ? 2'b10 : 2'b01) : 2'b00;
        mem_write_en = state == ACCESS && we_q && !rst;
        mem_read     = state == ACCESS && !we_q && !rst;
    end

    // FSM, command capture and read-data return
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last      <= ID_R1;
            we_q      <= 1'b0;
            id_q      <= ID_R0;
            addr_q    <= '0;
            wdata_q   <= '0;
            r0_rvalid <= 1'b0;
            r1_rvalid <= 1'b0;
            r0_rdata  <= '0;
            r1_rdata  <= '0;
        end else if (state == ACCESS) begin
            state     <= IDLE;
            r0_rvalid <= !we_q && id_q == ID_R0;
            r1_rvalid <= !we_q && id_q == ID_R1;
            if (!we_q && id_q == ID_R0) r0_rdata <= mem_read_data;
            if (!we_q && id_q == ID_R1) r1_rdata <= mem_read_data;
        end else begin
            r0_rvalid <= 1'b0;
            r1_rvalid <= 1'b0;
            if (any) begin
                state   <= ACCESS;
                last    <= win;
                id_q    <= win;
                we_q    <= win ? r1_we : r0_we;
                addr_q  <= win ? r1_addr : r0_addr;
                wdata_q <= win ? r1_wdata : r0_wdata;
            end
        end
    end

`ifdef DMEM_ARB_PERF_EN
    // saturating grant and conflict counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r0_gnt_cnt   <= '0;
            r1_gnt_cnt   <= '0;
            conflict_cnt <= '0;
        end else begin
            r0_gnt_cnt   <= sat_inc(r0_gnt_cnt, gnt[0]);
            r1_gnt_cnt   <= sat_inc(r1_gnt_cnt, gnt[1]);
            conflict_cnt <= sat_inc(conflict_cnt, state == IDLE && r0_req && r1_req);
        end
    end
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vector table plus hand sequences for fairness, mid-access reset and DMEM_ARB_PERF_EN counters
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        r0_req = 1'b0, r0_we = 1'b0, r1_req = 1'b0, r1_we = 1'b0;
    logic [15:0] r0_addr = '0, r0_wdata = '0, r1_addr = '0, r1_wdata = '0;
    logic        r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, mem_write_en, mem_read;
    logic [15:0] r0_rdata, r1_rdata, mem_access_addr, mem_write_data, mem_read_data;
`ifdef DMEM_ARB_PERF_EN
    logic [15:0] r0_gnt_cnt, r1_gnt_cnt, conflict_cnt;
`endif
    logic [15:0] mem [8] = '{16'hC000, 16'hC001, 16'hC002, 16'hC003,
                             16'hC004, 16'hC005, 16'hC006, 16'hC007};
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_write_en) mem[mem_access_addr[2:0]] <= mem_write_data;
    assign mem_read_data = mem[mem_access_addr[2:0]];

    dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r0_gnt(r0_gnt), .r1_gnt(r1_gnt), .r0_rvalid(r0_rvalid), .r1_rvalid(r1_rvalid),
        .r0_rdata(r0_rdata), .r1_rdata(r1_rdata),
        .mem_access_addr(mem_access_addr), .mem_write_data(mem_write_data),
        .mem_write_en(mem_write_en), .mem_read(mem_read), .mem_read_data(mem_read_data)
`ifdef DMEM_ARB_PERF_EN
        , .r0_gnt_cnt(r0_gnt_cnt), .r1_gnt_cnt(r1_gnt_cnt), .conflict_cnt(conflict_cnt)
`endif
    );

    typedef struct {
        logic        rst, q0, w0;
        logic [15:0] a0, d0;
        logic        q1, w1;
        logic [15:0] a1, d1;
        logic        g0, g1, v0, v1, mwe, mrd;
        logic [15:0] rd0, rd1;
    } vec_t;

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs [13];
        int k, c0, c1, g0n, g1n;
        logic exp_w;
        // reset with a pending r0 write to addr 6 must not grant or write
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 16'd6, 16'hFFFF, 1'b0, 1'b0, 16'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0};
        vecs[1]  = vecs[0];
        // r0 write A5A5 to addr 3, then read it back
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 16'd3, 16'hA5A5, 1'b0, 1'b0, 16'd0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 16'd0, 16'h0, 1'b0, 1'b0, 16'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 16'd3, 16'h0, 1'b0, 1'b0, 16'd0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 16'd0, 16'h0, 1'b0, 1'b0, 16'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 16'd0, 16'h0, 1'b0, 1'b0, 16'd0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'hA5A5, 16'h0};
        // reset, then simultaneous reads: r0 first, r1 two cycles later
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 16'd0, 16'h0, 1'b0, 1'b0, 16'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'hA5A5, 16'h0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 16'd1, 16'h0, 1'b1, 1'b0, 16'd2, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 16'd0, 16'h0, 1'b1, 1'b0, 16'd2, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 16'd0, 16'h0, 1'b1, 1'b0, 16'd2, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'hC001, 16'h0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 16'd0, 16'h0, 1'b0, 1'b0, 16'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hC001, 16'h0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 16'd0, 16'h0, 1'b0, 1'b0, 16'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'hC001, 16'hC002};

        for (int i = 0; i < 13; i++) begin
            @(posedge clk); #1;
            rst = vecs[i].rst;
            r0_req = vecs[i].q0; r0_we = vecs[i].w0; r0_addr = vecs[i].a0; r0_wdata = vecs[i].d0;
            r1_req = vecs[i].q1; r1_we = vecs[i].w1; r1_addr = vecs[i].a1; r1_wdata = vecs[i].d1;
            @(negedge clk);
            chk1($sformatf("v%0d r0_gnt", i), r0_gnt, vecs[i].g0);
            chk1($sformatf("v%0d r1_gnt", i), r1_gnt, vecs[i].g1);
            chk1($sformatf("v%0d r0_rvalid", i), r0_rvalid, vecs[i].v0);
            chk1($sformatf("v%0d r1_rvalid", i), r1_rvalid, vecs[i].v1);
            chk1($sformatf("v%0d mem_write_en", i), mem_write_en, vecs[i].mwe);
            chk1($sformatf("v%0d mem_read", i), mem_read, vecs[i].mrd);
            chk16($sformatf("v%0d r0_rdata", i), r0_rdata, vecs[i].rd0);
            chk16($sformatf("v%0d r1_rdata", i), r1_rdata, vecs[i].rd1);
        end
        chk16("mem3 written", mem[3], 16'hA5A5);
        chk16("mem6 untouched by reset", mem[6], 16'hC006);

        // fairness: both reads held, grants alternate r0,r1,... for 8 accesses
        k = 0; c0 = 0; c1 = 0; exp_w = 1'b0;
        @(posedge clk); #1;
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 16'd1;
        r1_req = 1'b1; r1_we = 1'b0; r1_addr = 16'd2;
        for (int c = 0; c < 40 && k < 8; c++) begin
            @(negedge clk);
            if (r0_gnt || r1_gnt) begin
                chk1("fair single gnt", r0_gnt & r1_gnt, 1'b0);
                chk1($sformatf("fair order %0d", k), r1_gnt, exp_w);
                exp_w = ~exp_w;
                k++;
                if (r0_gnt) c0++; else c1++;
            end
            if (r0_rvalid) chk16("fair r0_rdata", r0_rdata, 16'hC001);
            if (r1_rvalid) chk16("fair r1_rdata", r1_rdata, 16'hC002);
            @(posedge clk);
        end
        #1;
        r0_req = 1'b0; r1_req = 1'b0;
        chk1("fair 8 grants", k == 8, 1'b1);
        chk1("fair r0 count 4", c0 == 4, 1'b1);
        chk1("fair r1 count 4", c1 == 4, 1'b1);
        repeat (2) @(posedge clk);

        // reset during the ACCESS cycle of an r1 write
        @(posedge clk); #1;
        r1_req = 1'b1; r1_we = 1'b1; r1_addr = 16'd5; r1_wdata = 16'h1234;
        @(negedge clk);
        chk1("mid r1_gnt", r1_gnt, 1'b1);
        @(posedge clk); #1;
        r1_req = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk1("mid mem_write_en gated", mem_write_en, 1'b0);
        chk1("mid mem_read gated", mem_read, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk1("mid r0_rvalid", r0_rvalid, 1'b0);
        chk1("mid r1_rvalid", r1_rvalid, 1'b0);
        chk16("mid mem5 unchanged", mem[5], 16'hC005);
        chk16("mid r1_rdata cleared", r1_rdata, 16'h0);
        @(posedge clk); #1;
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 16'd5;
        @(negedge clk);
        chk1("mid idle r0_gnt", r0_gnt, 1'b1);
        @(posedge clk); #1;
        r0_req = 1'b0;
        @(negedge clk);
        chk1("mid mem_read", mem_read, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        chk1("mid r0_rvalid read", r0_rvalid, 1'b1);
        chk16("mid r0_rdata", r0_rdata, 16'hC005);

`ifdef DMEM_ARB_PERF_EN
        // 3 conflicting IDLE cycles then 2 solo r0 grants
        g0n = 0; g1n = 0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 16'd1;
        r1_req = 1'b1; r1_we = 1'b0; r1_addr = 16'd2;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            g0n += int'(r0_gnt);
            g1n += int'(r1_gnt);
            @(posedge clk); #1;
            if (i == 5) r1_req = 1'b0;
            if (i == 9) r0_req = 1'b0;
        end
        @(negedge clk);
        chk16("perf conflict_cnt", conflict_cnt, 16'd3);
        chk16("perf r0_gnt_cnt", r0_gnt_cnt, 16'd4);
        chk16("perf r1_gnt_cnt", r1_gnt_cnt, 16'd1);
        chk1("perf r0 cnt matches pulses", r0_gnt_cnt == 16'(g0n), 1'b1);
        chk1("perf r1 cnt matches pulses", r1_gnt_cnt == 16'(g1n), 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
